dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Wishbone bus master that configures and sequences a `simple_dds` instance to run a linear frequency sweep. It polls READY, programs DDS_SRC/GAIN_WORD/OFFSET_WORD, then repeatedly rewrites TUNING_WORD from a start value to a stop value in fixed steps, holding each step for a programmable dwell, and finally disables the DDS. It sits between host-side control logic and the DDS Wishbone slave port, in the `wb_clk_i` domain.

## Interface
- DATA_WIDTH, 32, Wishbone data width (matches DDS).
- ADDR_WIDTH, 16, Wishbone address width (matches DDS).
- DWELL_WIDTH, 24, width of dwell counter and `dwell_i`.
- TIMEOUT_CYCLES, 16, ack watchdog limit (used only with DDS_SWEEP_ACK_TIMEOUT_EN).

- wb_clk_i  in  1  single clock, all logic on rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  one-cycle pulse; starts a sweep when idle.
- stop_i  in  1  one-cycle pulse; aborts a running sweep.
- src_i  in  2  waveform select written to DDS_SRC.
- gain_i  in  2  written to GAIN_WORD.
- offset_i  in  16  written to OFFSET_WORD.
- tw_start_i / tw_stop_i / tw_step_i  in  16 each  sweep tuning words.
- dwell_i  in  DWELL_WIDTH  cycles to hold each tuning word (0 treated as 1).
- wb_addr_o  out  ADDR_WIDTH  DDS register address.
- wb_dat_o  out  DATA_WIDTH  write data, zero-extended fields.
- wb_we_o  out  1  write enable.
- wb_stb_o  out  1  strobe.
- wb_dat_i  in  DATA_WIDTH  read data from DDS.
- wb_ack_i  in  1  acknowledge from DDS.
- busy_o  out  1  high from accepted start until return to IDLE.
- done_o  out  1  one-cycle pulse on return to IDLE.
- err_o  out  1  sticky ack timeout flag; cleared by next accepted start.
- cur_tw_o  out  16  tuning word most recently acked by DDS.

## Operation
- Register map: READY=0, ENABLE=1, DDS_SRC=2, TUNING_WORD=3, GAIN_WORD=4, OFFSET_WORD=5.
- States: IDLE, POLL, SRC, GAIN, OFFS, TW, EN, DWELL, STEP, DIS, DONE.
- IDLE: on `start_i`, latch all config inputs, clear `err_o`, go POLL. `start_i` ignored when not IDLE.
- POLL: read addr 0; on ack, if `wb_dat_i[0]==1` go SRC, else reissue read.
- SRC -> GAIN -> OFFS -> TW -> EN: one write each (EN writes 1 to ENABLE); next state entered on ack.
- TW writes current word `cur` (initially tw_start); on ack, `cur_tw_o <= cur`. From first TW go EN; afterwards go DWELL.
- DWELL: count max(dwell_i,1) cycles, then STEP.
- STEP: nxt = {1'b0,cur} + tw_step (17-bit). If tw_step==0, or nxt[16]==1, or nxt[15:0] > tw_stop, go DIS; else cur <= nxt[15:0], go TW.
- tw_start > tw_stop: single point at tw_start, then DIS.
- DIS: write 0 to ENABLE; on ack go DONE. DONE: pulse `done_o`, go IDLE.
- `stop_i` in any non-IDLE state: set internal abort flag; current transaction completes (strobe never dropped before ack); then go DIS. `stop_i` during DIS/DONE has no effect. If abort occurs before EN, DIS still writes ENABLE=0.

## Timing
- Reset values: all outputs 0; state IDLE; `cur_tw_o`=0.
- Reset asserted mid-transaction: `wb_stb_o` low on the next edge, no completion.
- Transaction: addr/data/we/stb driven from a register; held stable until `wb_ack_i` sampled high; stb deasserted on that same edge. At least one stb-low cycle between transactions.
- With a 1-cycle-registered-ack slave: each write = 2 stb-high cycles + 1 idle = 3 cycles.
- `start_i` to first stb: 1 cycle. Step period in sweep = 3 (TW write) + dwell + 1 (STEP) cycles.
- `done_o` asserted for exactly one cycle; `busy_o` drops the same cycle as `done_o`.

## Configuration
- DDS_SWEEP_ACK_TIMEOUT_EN defined: counter runs while stb high; if TIMEOUT_CYCLES elapse without ack, drop stb, set `err_o`, go DONE (no DIS write). Counter reset on each new transaction.
- Not defined: controller waits indefinitely for ack; `err_o` tied 0.

## Test plan
- Reset then start with src=1, gain=2, offset=0x0100, tw 0x10->0x30 step 0x10, dwell=4 -> writes in order: read 0 (returns 1), 2<-1, 4<-2, 5<-0x100, 3<-0x10, 1<-1, 3<-0x20, 3<-0x30, 1<-0; one `done_o` pulse.
- READY model returns 0 three times then 1 -> exactly four reads of addr 0 before DDS_SRC write.
- tw_start=0xFFF0, step=0x20, stop=0xFFFF -> only 0xFFF0 written (carry ends sweep), then ENABLE<-0.
- `stop_i` pulsed during second TW write stb -> that write acks, `cur_tw_o`=second word, next transaction is ENABLE<-0, `done_o` pulses.
- `wb_rst_i` asserted mid-DWELL -> next cycle all outputs 0, state IDLE; new `start_i` restarts from POLL.
- With DDS_SWEEP_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> stb drops after 16 cycles, `err_o`=1, `done_o` pulses; next start clears `err_o`.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Wishbone master that programs a simple_dds and steps TUNING_WORD from tw_start to tw_stop.
// Optional ack watchdog: define DDS_SWEEP_ACK_TIMEOUT_EN.
module dds_sweep_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DWELL_WIDTH    = 24,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [1:0]             src_i,
  input  logic [1:0]             gain_i,
  input  logic [15:0]            offset_i,
  input  logic [15:0]            tw_start_i,
  input  logic [15:0]            tw_stop_i,
  input  logic [15:0]            tw_step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output logic [ADDR_WIDTH-1:0]  wb_addr_o,
  output logic [DATA_WIDTH-1:0]  wb_dat_o,
  output logic                   wb_we_o,
  output logic                   wb_stb_o,
  input  logic [DATA_WIDTH-1:0]  wb_dat_i,
  input  logic                   wb_ack_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [15:0]            cur_tw_o
);

  localparam logic [ADDR_WIDTH-1:0] A_READY = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_EN    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_SRC   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_TW    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_GAIN  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_OFFS  = ADDR_WIDTH'(5);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_SRC, S_GAIN, S_OFFS, S_TW, S_EN, S_DWELL, S_STEP, S_DIS, S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_stb;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_dat;
  logic                   r_busy;
  logic                   r_done;
  logic [15:0]            r_cur_tw;
  logic                   r_abort;
  logic                   r_en_done;
  logic [1:0]             r_src;
  logic [1:0]             r_gain;
  logic [15:0]            r_offs;
  logic [15:0]            r_stop;
  logic [15:0]            r_step;
  logic [15:0]            r_cur;
  logic [DWELL_WIDTH-1:0] r_dwell;
  logic [DWELL_WIDTH-1:0] r_cnt;

`ifdef DDS_SWEEP_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic            r_err;
  logic [TO_W-1:0] r_to;
`endif

  logic                   w_bus_state;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_dat;
  logic                   w_we;
  logic                   w_ack;
  logic                   w_abort;
  logic [16:0]            w_nxt;
  logic                   w_step_end;
  logic [DWELL_WIDTH-1:0] w_dwell_ld;
  logic                   w_unused;

  assign w_ack      = r_stb & wb_ack_i;
  assign w_abort    = r_abort | stop_i;
  assign w_nxt      = {1'b0, r_cur} + {1'b0, r_step};
  assign w_step_end = (r_step == 16'd0) | w_nxt[16] | (w_nxt[15:0] > r_stop);
  assign w_dwell_ld = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
  assign w_unused   = ^{wb_dat_i[DATA_WIDTH-1:1], TIMEOUT_CYCLES[0]};

  // Address/data of the transaction each bus state issues
  always_comb begin
    w_bus_state = 1'b1;
    w_addr      = A_READY;
    w_dat       = '0;
    w_we        = 1'b1;
    case (r_state)
      S_POLL:  w_we = 1'b0;
      S_SRC:   begin w_addr = A_SRC;  w_dat = DATA_WIDTH'(r_src);  end
      S_GAIN:  begin w_addr = A_GAIN; w_dat = DATA_WIDTH'(r_gain); end
      S_OFFS:  begin w_addr = A_OFFS; w_dat = DATA_WIDTH'(r_offs); end
      S_TW:    begin w_addr = A_TW;   w_dat = DATA_WIDTH'(r_cur);  end
      S_EN:    begin w_addr = A_EN;   w_dat = DATA_WIDTH'(1);      end
      S_DIS:   w_addr = A_EN;
      default: begin w_bus_state = 1'b0; w_we = 1'b0; end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_dat     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cur_tw  <= '0;
      r_abort   <= 1'b0;
      r_en_done <= 1'b0;
`ifdef DDS_SWEEP_ACK_TIMEOUT_EN
      r_err     <= 1'b0;
      r_to      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (stop_i && r_state != S_IDLE && r_state != S_DIS && r_state != S_DONE)
        r_abort <= 1'b1;

      // A bus state with strobe low has nothing outstanding: issue, or divert on abort
      if (w_bus_state && !r_stb) begin
        if (w_abort && r_state != S_DIS) begin
          r_state <= S_DIS;
        end else begin
          r_stb  <= 1'b1;
          r_addr <= w_addr;
          r_dat  <= w_dat;
          r_we   <= w_we;
        end
      end

      case (r_state)
        S_IDLE: if (start_i) begin
          r_src     <= src_i;
          r_gain    <= gain_i;
          r_offs    <= offset_i;
          r_stop    <= tw_stop_i;
          r_step    <= tw_step_i;
          r_cur     <= tw_start_i;
          r_dwell   <= dwell_i;
          r_abort   <= 1'b0;
          r_en_done <= 1'b0;
          r_busy    <= 1'b1;
          r_stb     <= 1'b1;
          r_addr    <= A_READY;
          r_we      <= 1'b0;
          r_dat     <= '0;
          r_state   <= S_POLL;
`ifdef DDS_SWEEP_ACK_TIMEOUT_EN
          r_err     <= 1'b0;
`endif
        end
        S_POLL: if (w_ack) begin
          r_stb <= 1'b0;
          if (w_abort)         r_state <= S_DIS;
          else if (wb_dat_i[0]) r_state <= S_SRC;
        end
        S_SRC:  if (w_ack) begin r_stb <= 1'b0; r_state <= w_abort ? S_DIS : S_GAIN; end
        S_GAIN: if (w_ack) begin r_stb <= 1'b0; r_state <= w_abort ? S_DIS : S_OFFS; end
        S_OFFS: if (w_ack) begin r_stb <= 1'b0; r_state <= w_abort ? S_DIS : S_TW;   end
        S_TW: if (w_ack) begin
          r_stb    <= 1'b0;
          r_cur_tw <= r_cur;
          if (w_abort)         r_state <= S_DIS;
          else if (!r_en_done) r_state <= S_EN;
          else begin r_state <= S_DWELL; r_cnt <= w_dwell_ld; end
        end
        S_EN: if (w_ack) begin
          r_stb     <= 1'b0;
          r_en_done <= 1'b1;
          if (w_abort) r_state <= S_DIS;
          else begin r_state <= S_DWELL; r_cnt <= w_dwell_ld; end
        end
        S_DWELL: begin
          if (w_abort)          r_state <= S_DIS;
          else if (r_cnt == '0) r_state <= S_STEP;
          else                  r_cnt   <= r_cnt - 1'b1;
        end
        S_STEP: begin
          if (w_abort || w_step_end) r_state <= S_DIS;
          else begin r_cur <= w_nxt[15:0]; r_state <= S_TW; end
        end
        S_DIS: if (w_ack) begin r_stb <= 1'b0; r_state <= S_DONE; end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef DDS_SWEEP_ACK_TIMEOUT_EN
      // Watchdog overrides the state decision above
      if (r_stb && !wb_ack_i) r_to <= r_to + 1'b1;
      else                    r_to <= '0;
      if (r_stb && !wb_ack_i && r_to == TO_LAST) begin
        r_stb   <= 1'b0;
        r_err   <= 1'b1;
        r_to    <= '0;
        r_state <= S_DONE;
      end
`endif
    end
  end

  assign wb_addr_o = r_addr;
  assign wb_dat_o  = r_dat;
  assign wb_we_o   = r_we;
  assign wb_stb_o  = r_stb;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign cur_tw_o  = r_cur_tw;
`ifdef DDS_SWEEP_ACK_TIMEOUT_EN
  assign err_o     = r_err;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: directed sweeps against a registered-ack DDS slave model.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [1:0]  src_i = '0;
  logic [1:0]  gain_i = '0;
  logic [15:0] offset_i = '0;
  logic [15:0] tw_start_i = '0;
  logic [15:0] tw_stop_i = '0;
  logic [15:0] tw_step_i = '0;
  logic [23:0] dwell_i = '0;
  logic [15:0] wb_addr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we, wb_stb;
  logic        wb_ack = 1'b0;
  logic        busy, done, err;
  logic [15:0] cur_tw;

  txn_t exp_q[$];
  int   tw_cyc[$];
  int   n_chk = 0, n_fail = 0;
  int   done_cnt = 0, cyc = 0, zeros = 0, rd_n = 0;
  int   run = 0, last_run = 0;
  logic noack = 1'b0;

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .stop_i(stop_i),
    .src_i(src_i), .gain_i(gain_i), .offset_i(offset_i),
    .tw_start_i(tw_start_i), .tw_stop_i(tw_stop_i), .tw_step_i(tw_step_i),
    .dwell_i(dwell_i), .wb_addr_o(wb_addr), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we),
    .wb_stb_o(wb_stb), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
    .busy_o(busy), .done_o(done), .err_o(err), .cur_tw_o(cur_tw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // DDS slave: ack registered one cycle after strobe; READY reads 0 for 'zeros' polls
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wb_stb && !wb_ack && !noack) begin
      wb_ack <= 1'b1;
      if (!wb_we && wb_addr == 16'd0) begin
        wb_dat_i <= (rd_n >= zeros) ? 32'd1 : 32'd0;
        rd_n     <= rd_n + 1;
      end
    end else begin
      wb_ack <= 1'b0;
    end
    if (start_i) rd_n <= 0;
  end

  // Monitor: pop the scoreboard on every acknowledged transaction
  always @(negedge clk) begin
    if (wb_stb) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (done) begin
      done_cnt++;
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    end
    if (wb_stb && wb_ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_txn: got addr=0x%0h we=%0b dat=0x%0h expected none",
                 wb_addr, wb_we, wb_dat_o);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        chk("txn_addr", {16'd0, wb_addr}, {16'd0, e.addr});
        chk("txn_we", {31'd0, wb_we}, {31'd0, e.we});
        if (e.we) chk("txn_dat", wb_dat_o, e.dat);
      end
      if (wb_we && wb_addr == 16'd3) tw_cyc.push_back(cyc);
    end
  end

  task automatic push(input logic [15:0] a, input logic we, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = we; t.dat = d;
    exp_q.push_back(t);
  endtask

  task automatic start(input logic [1:0] s, input logic [1:0] g, input logic [15:0] o,
                       input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] st,
                       input logic [23:0] dw);
    @(posedge clk); #1;
    src_i = s; gain_i = g; offset_i = o;
    tw_start_i = t0; tw_stop_i = t1; tw_step_i = st; dwell_i = dw;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("start_to_stb", {31'd0, wb_stb}, 32'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxc && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_addr", {16'd0, wb_addr}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_cur_tw", {16'd0, cur_tw}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic sweep 0x10 -> 0x30 step 0x10, dwell 4
    zeros = 0;
    tw_cyc.delete();
    push(16'd0, 1'b0, 32'd0);
    push(16'd2, 1'b1, 32'd1);
    push(16'd4, 1'b1, 32'd2);
    push(16'd5, 1'b1, 32'h100);
    push(16'd3, 1'b1, 32'h10);
    push(16'd1, 1'b1, 32'd1);
    push(16'd3, 1'b1, 32'h20);
    push(16'd3, 1'b1, 32'h30);
    push(16'd1, 1'b1, 32'd0);
    start(2'd1, 2'd2, 16'h0100, 16'h10, 16'h30, 16'h10, 24'd4);
    wait_done(500);
    chk("sweep_cur_tw", {16'd0, cur_tw}, 32'h30);
    chk("tw_write_count", tw_cyc.size(), 32'd3);
    chk("step_period", (tw_cyc.size() >= 3) ? tw_cyc[2] - tw_cyc[1] : -1, 32'd8);

    // READY low for three polls
    zeros = 3;
    repeat (4) push(16'd0, 1'b0, 32'd0);
    push(16'd2, 1'b1, 32'd0);
    push(16'd4, 1'b1, 32'd1);
    push(16'd5, 1'b1, 32'hABCD);
    push(16'd3, 1'b1, 32'h10);
    push(16'd1, 1'b1, 32'd1);
    push(16'd1, 1'b1, 32'd0);
    start(2'd0, 2'd1, 16'hABCD, 16'h10, 16'h10, 16'h1, 24'd1);
    wait_done(500);
    zeros = 0;

    // tw_start above tw_stop with dwell 0: single point
    push(16'd0, 1'b0, 32'd0);
    push(16'd2, 1'b1, 32'd3);
    push(16'd4, 1'b1, 32'd3);
    push(16'd5, 1'b1, 32'hFFFF);
    push(16'd3, 1'b1, 32'h50);
    push(16'd1, 1'b1, 32'd1);
    push(16'd1, 1'b1, 32'd0);
    start(2'd3, 2'd3, 16'hFFFF, 16'h50, 16'h20, 16'h1, 24'd0);
    wait_done(500);
    chk("single_point_cur_tw", {16'd0, cur_tw}, 32'h50);

    // Abort during the second TW write
    begin
      logic found;
      found = 1'b0;
      push(16'd0, 1'b0, 32'd0);
      push(16'd2, 1'b1, 32'd1);
      push(16'd4, 1'b1, 32'd0);
      push(16'd5, 1'b1, 32'h10);
      push(16'd3, 1'b1, 32'h10);
      push(16'd1, 1'b1, 32'd1);
      push(16'd3, 1'b1, 32'h20);
      push(16'd1, 1'b1, 32'd0);
      start(2'd1, 2'd0, 16'h10, 16'h10, 16'h30, 16'h10, 24'd2);
      for (int i = 0; i < 300 && !found; i++) begin
        @(negedge clk);
        if (wb_stb && wb_we && wb_addr == 16'd3 && wb_dat_o == 32'h20) found = 1'b1;
      end
      chk("stop_window_found", {31'd0, found}, 32'd1);
      stop_i = 1'b1;
      @(posedge clk); #1;
      stop_i = 1'b0;
      wait_done(500);
      chk("abort_cur_tw", {16'd0, cur_tw}, 32'h20);
    end

    // Reset in the middle of DWELL
    push(16'd0, 1'b0, 32'd0);
    push(16'd2, 1'b1, 32'd2);
    push(16'd4, 1'b1, 32'd1);
    push(16'd5, 1'b1, 32'h55);
    push(16'd3, 1'b1, 32'h100);
    push(16'd1, 1'b1, 32'd1);
    start(2'd2, 2'd1, 16'h55, 16'h100, 16'h200, 16'h80, 24'd200);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_stb", {31'd0, wb_stb}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cur_tw", {16'd0, cur_tw}, 32'd0);
    chk("midrst_bus", {wb_addr, 15'd0, wb_we} | wb_dat_o, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Restart after reset: carry out of 16 bits ends the sweep
    push(16'd0, 1'b0, 32'd0);
    push(16'd2, 1'b1, 32'd1);
    push(16'd4, 1'b1, 32'd1);
    push(16'd5, 1'b1, 32'd0);
    push(16'd3, 1'b1, 32'hFFF0);
    push(16'd1, 1'b1, 32'd1);
    push(16'd1, 1'b1, 32'd0);
    start(2'd1, 2'd1, 16'h0, 16'hFFF0, 16'hFFFF, 16'h20, 24'd1);
    wait_done(500);
    chk("carry_cur_tw", {16'd0, cur_tw}, 32'hFFF0);

`ifdef DDS_SWEEP_ACK_TIMEOUT_EN
    noack = 1'b1;
    start(2'd1, 2'd1, 16'h0, 16'h10, 16'h10, 16'h1, 24'd1);
    wait_done(100);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_stb_cycles", last_run, 32'd16);
    noack = 1'b0;
    push(16'd0, 1'b0, 32'd0);
    push(16'd2, 1'b1, 32'd1);
    push(16'd4, 1'b1, 32'd1);
    push(16'd5, 1'b1, 32'd0);
    push(16'd3, 1'b1, 32'h10);
    push(16'd1, 1'b1, 32'd1);
    push(16'd1, 1'b1, 32'd0);
    start(2'd1, 2'd1, 16'h0, 16'h10, 16'h10, 16'h1, 24'd1);
    chk("err_cleared", {31'd0, err}, 32'd0);
    wait_done(500);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

endmodule
